// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : riscv32 instruction fetch front-end. Issues ROM reads under a
//            credit rule, captures the 1-cycle ROM response, buffers
//            {pc, inst} in a small FIFO and serves decode via valid/ready.
//            A redirect flushes the buffer and restarts fetch.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_en,
  output logic        rom_rx_valid,
  output logic [31:0] rom_rx_addr,
  input  logic        rom_tx_valid,
  input  logic [31:0] rom_tx_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [CW:0] c_depth    = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_full   = CW'(FIFO_DEPTH);
  localparam logic [31:0] c_nop      = 32'h0000_0013;

  logic          r_alive;
  logic [31:0]   r_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_mem_pc   [FIFO_DEPTH];
  logic [31:0]   r_mem_inst [FIFO_DEPTH];

  logic          w_issue;
  logic          w_capture;
  logic          w_push;
  logic          w_pop;
  logic          w_not_empty;
  logic [CW:0]   w_occupancy;

  // Buffered entries plus the outstanding response must never exceed the FIFO.
  assign w_occupancy  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue      = r_alive & fetch_en & ~redirect_valid & (w_occupancy < c_depth);
  // rom_tx_valid is sticky, so only our own outstanding request qualifies it.
  assign w_capture    = r_inflight & rom_tx_valid;
  assign w_push       = w_capture & ~redirect_valid;
  assign w_not_empty  = (r_count != '0);
  assign w_pop        = if_valid & if_ready;

  assign rom_rx_valid = w_issue;
  assign rom_rx_addr  = r_pc;
  assign if_valid     = w_not_empty & ~redirect_valid;
  assign if_inst      = w_not_empty ? r_mem_inst[r_rd_ptr] : c_nop;
  assign if_pc        = w_not_empty ? r_mem_pc[r_rd_ptr]   : 32'h0000_0000;

  // Fetch PC, outstanding-request tracking and the start-up gate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_alive       <= 1'b0;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0000_0000;
    end else begin
      r_alive    <= 1'b1;
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_pc <= redirect_pc & 32'hFFFF_FFFC;
      end else if (w_issue) begin
        r_pc          <= r_pc + 32'd4;
        r_inflight_pc <= r_pc;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect flush takes priority over push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect_valid) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
      r_mem_inst[r_wr_ptr] <= rom_tx_data;
    end
  end

  // The credit rule must make a push into a full buffer impossible.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
    !(w_push && (r_count == c_full)));

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Purpose  : directed, table-driven bench for inst_fetch_unit with a
//            1-cycle-latency sticky-valid ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rdv;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_en;
  logic        rom_rx_valid;
  logic [31:0] rom_rx_addr;
  logic        rom_tx_valid = 1'b0;
  logic [31:0] rom_tx_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs_a[$];
  vec_t vecs_b[$];

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .fetch_en       (fetch_en),
    .rom_rx_valid   (rom_rx_valid),
    .rom_rx_addr    (rom_rx_addr),
    .rom_tx_valid   (rom_tx_valid),
    .rom_tx_data    (rom_tx_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  // ROM contents: mem[i] = 0x100 + i, word index i = addr >> 2.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h100 + (addr >> 2);
  endfunction

  // ROM: 1-cycle latency, valid stays high after the first read.
  always @(posedge clk) begin
    if (rom_rx_valid) begin
      rom_tx_valid <= 1'b1;
      rom_tx_data  <= rom_word(rom_rx_addr);
    end
  end

  function automatic vec_t mk(input logic fe, input logic rdy, input logic rdv,
                              input logic [31:0] rpc, input logic e_rv,
                              input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rdv = rdv; v.rpc = rpc;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_rv, input logic [31:0] e_addr,
                            input logic e_iv, input logic [31:0] e_pc, input logic [31:0] e_inst);
    n_vec++;
    check({tag, ".rom_rx_valid"}, {31'b0, rom_rx_valid}, {31'b0, e_rv});
    check({tag, ".rom_rx_addr"},  rom_rx_addr, e_addr);
    check({tag, ".if_valid"},     {31'b0, if_valid}, {31'b0, e_iv});
    check({tag, ".if_pc"},        if_pc, e_pc);
    check({tag, ".if_inst"},      if_inst, e_inst);
  endtask

  // Called at a negedge: drive, settle, compare, move to next negedge.
  task automatic apply(input string tag, input vec_t v);
    fetch_en       = v.fe;
    if_ready       = v.rdy;
    redirect_valid = v.rdv;
    redirect_pc    = v.rpc;
    #1;
    check_outs(tag, v.e_rv, v.e_addr, v.e_iv, v.e_pc, v.e_inst);
    @(negedge clk);
  endtask

  initial begin
    // Streaming: first issue in c1, first output in c3.
    vecs_a.push_back(mk(1,1,0,0, 0,32'h0, 0,0,c_nop));
    vecs_a.push_back(mk(1,1,0,0, 1,32'h0, 0,0,c_nop));
    vecs_a.push_back(mk(1,1,0,0, 1,32'h4, 0,0,c_nop));
    for (int k = 3; k <= 8; k++)
      vecs_a.push_back(mk(1,1,0,0, 1,32'(4*(k-1)), 1,32'(4*(k-3)),32'(32'h100 + k - 3)));
    // Backpressure: issue stops once count + inflight = 4, then resumes.
    vecs_a.push_back(mk(1,0,0,0, 1,32'h20, 1,32'h18,32'h106));
    vecs_a.push_back(mk(1,0,0,0, 1,32'h24, 1,32'h18,32'h106));
    vecs_a.push_back(mk(1,0,0,0, 0,32'h28, 1,32'h18,32'h106));
    vecs_a.push_back(mk(1,0,0,0, 0,32'h28, 1,32'h18,32'h106));
    vecs_a.push_back(mk(1,1,0,0, 0,32'h28, 1,32'h18,32'h106));
    vecs_a.push_back(mk(1,1,0,0, 1,32'h28, 1,32'h1C,32'h107));
    vecs_a.push_back(mk(1,1,0,0, 1,32'h2C, 1,32'h20,32'h108));
    vecs_a.push_back(mk(1,1,0,0, 1,32'h30, 1,32'h24,32'h109));
    vecs_a.push_back(mk(1,1,0,0, 1,32'h34, 1,32'h28,32'h10A));
    // Redirect to 0x203 at full credit with a response outstanding.
    vecs_a.push_back(mk(1,0,0,0,          1,32'h38, 1,32'h2C,32'h10B));
    vecs_a.push_back(mk(1,0,1,32'h203,    0,32'h3C, 0,32'h2C,32'h10B));
    vecs_a.push_back(mk(1,1,0,0,          1,32'h200, 0,0,c_nop));
    vecs_a.push_back(mk(1,1,0,0,          1,32'h204, 0,0,c_nop));
    vecs_a.push_back(mk(1,1,0,0,          1,32'h208, 1,32'h200,32'h180));
    vecs_a.push_back(mk(1,1,0,0,          1,32'h20C, 1,32'h204,32'h181));
    // fetch_en dropped right after an issue at 0x10.
    vecs_a.push_back(mk(1,1,1,32'h10,     0,32'h210, 0,32'h208,32'h182));
    vecs_a.push_back(mk(1,1,0,0,          1,32'h10, 0,0,c_nop));
    vecs_a.push_back(mk(0,1,0,0,          0,32'h14, 0,0,c_nop));
    vecs_a.push_back(mk(0,1,0,0,          0,32'h14, 1,32'h10,32'h104));
    vecs_a.push_back(mk(0,1,0,0,          0,32'h14, 0,0,c_nop));
    vecs_a.push_back(mk(0,1,0,0,          0,32'h14, 0,0,c_nop));
    // PC wrap from 0xFFFF_FFFC to 0.
    vecs_a.push_back(mk(1,1,1,32'hFFFF_FFFC, 0,32'h14, 0,0,c_nop));
    vecs_a.push_back(mk(1,1,0,0, 1,32'hFFFF_FFFC, 0,0,c_nop));
    vecs_a.push_back(mk(1,1,0,0, 1,32'h0, 0,0,c_nop));
    vecs_a.push_back(mk(1,1,0,0, 1,32'h4, 1,32'hFFFF_FFFC,32'h4000_00FF));
    vecs_a.push_back(mk(1,1,0,0, 1,32'h8, 1,32'h0,32'h100));
    vecs_a.push_back(mk(1,1,0,0, 1,32'hC, 1,32'h4,32'h101));
    // Fill to count=3 with one response outstanding ahead of the reset.
    vecs_a.push_back(mk(1,0,0,0, 1,32'h10, 1,32'h8,32'h102));
    vecs_a.push_back(mk(1,0,0,0, 1,32'h14, 1,32'h8,32'h102));
    // After reset release: restart at RESET_PC, stale ROM data ignored.
    vecs_b.push_back(mk(1,1,0,0, 0,32'h0, 0,0,c_nop));
    vecs_b.push_back(mk(1,1,0,0, 1,32'h0, 0,0,c_nop));
    vecs_b.push_back(mk(1,1,0,0, 1,32'h4, 0,0,c_nop));
    vecs_b.push_back(mk(1,1,0,0, 1,32'h8, 1,32'h0,32'h100));
    vecs_b.push_back(mk(1,1,0,0, 1,32'hC, 1,32'h4,32'h101));

    rstn = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk); @(negedge clk);
    #1;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, c_nop);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs_a.size(); i++)
      apply($sformatf("a%0d", i), vecs_a[i]);

    // Mid-cycle asynchronous reset with count=3 and a response outstanding.
    fetch_en = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    check_outs("pre_rst", 1'b0, 32'h18, 1'b1, 32'h8, 32'h102);
    #1;
    rstn = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, c_nop);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs_b.size(); i++)
      apply($sformatf("b%0d", i), vecs_b[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
